// File: rtl/fifo_pop_drain_if.sv
// Downstream valid/ready stream carrying words drained from the FIFO.
// The drain block drives valid/data (master); the consumer drives ready.
interface fifo_pop_drain_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );
endinterface

// File: rtl/fifo_pop_drain.sv
// Pop-side consumer for the dual-clock FIFO.
// Drains the FIFO's active-low pop port into a two-slot prefetch buffer and
// presents the words as a valid/ready stream at one word per cycle. Also keeps
// a wrapping delivered-word counter and a sticky pop-side error flag.
module fifo_pop_drain #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_pop,
   input  logic                  rst_n,
   input  logic                  pop_empty,
   input  logic                  pop_error,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic                  pop_req_n,
   input  logic                  flush,
   fifo_pop_drain_if.master      m,
   output logic [1:0]            occupancy,
   output logic [CNT_WIDTH-1:0]  xfer_cnt,
   output logic                  err_sticky
);

   // Buffer fill level doubles as the FSM state.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_state_t;

   occ_state_t            state_reg;
   occ_state_t            state_next;
   logic                  run_reg;
   logic [DATA_WIDTH-1:0] slot0_reg;
   logic [DATA_WIDTH-1:0] slot0_next;
   logic [DATA_WIDTH-1:0] slot1_reg;
   logic [DATA_WIDTH-1:0] slot1_next;
   logic [CNT_WIDTH-1:0]  cnt_reg;
   logic [CNT_WIDTH-1:0]  cnt_next;
   logic                  err_reg;
   logic                  err_next;

   logic                  pop;
   logic                  xfer;
   logic                  valid_int;

   // Pop only from registered state and the FIFO empty flag, never from
   // m.ready, so the FIFO sees no combinational path from downstream.
   assign pop       = run_reg & ~flush & ~pop_empty & (state_reg != FULL);
   assign pop_req_n = ~pop;

   assign valid_int = (state_reg != EMPTY);
   assign xfer      = valid_int & m.ready;

   assign m.valid    = valid_int;
   assign m.data     = slot0_reg;
   assign occupancy  = state_reg;
   assign xfer_cnt   = cnt_reg;
   assign err_sticky = err_reg;

   // run holds off all pops until the first clock edge after reset release.
   always_ff @(posedge clk_pop or negedge rst_n) begin
      if (!rst_n) begin
         run_reg <= 1'b0;
      end else begin
         run_reg <= 1'b1;
      end
   end

   // State and buffer registers; reset discards buffered words immediately.
   always_ff @(posedge clk_pop or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= EMPTY;
         slot0_reg <= '0;
         slot1_reg <= '0;
      end else begin
         state_reg <= state_next;
         slot0_reg <= slot0_next;
         slot1_reg <= slot1_next;
      end
   end

   // Next-state and slot movement for pop/xfer combinations.
   always_comb begin
      state_next = state_reg;
      slot0_next = slot0_reg;
      slot1_next = slot1_reg;
      if (flush) begin
         // Slot contents are left stale; only the fill level is cleared.
         state_next = EMPTY;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (pop) begin
                  state_next = ONE;
                  slot0_next = data_out;
               end
            end
            ONE: begin
               if (pop && xfer) begin
                  slot0_next = data_out;
               end else if (pop) begin
                  state_next = FULL;
                  slot1_next = data_out;
               end else if (xfer) begin
                  state_next = EMPTY;
               end
            end
            FULL: begin
               // pop is impossible here; only the head can leave.
               if (xfer) begin
                  state_next = ONE;
                  slot0_next = slot1_reg;
               end
            end
            default: begin
               state_next = EMPTY;
            end
         endcase
      end
   end

   // Delivered-word counter and sticky error flag next values.
   always_comb begin
      cnt_next = cnt_reg;
      err_next = err_reg;
      // A transfer during a flush cycle still reached the consumer.
      if (xfer) begin
         cnt_next = cnt_reg + 1'b1;
      end
      if (flush) begin
         err_next = 1'b0;
      end else if (pop_error) begin
         err_next = 1'b1;
      end
   end

   // Counter and error flag registers.
   always_ff @(posedge clk_pop or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
         err_reg <= 1'b0;
      end else begin
         cnt_reg <= cnt_next;
         err_reg <= err_next;
      end
   end

endmodule
